jt1942_dwnld: RTL and testbench

ROM download router for the 1942 core. It sits between the framework's ioctl byte stream and the SDRAM programming port (prog_addr/prog_data/prog_mask/prog_we). It maps each downloaded byte to its SDRAM word address and byte lane, and interleaves the object ROM. It diverts palette/lookup PROM bytes to one-hot BRAM write strobes. A 2-entry buffer absorbs SDRAM write latency.

---
 rtl/jt1942_dwnld.sv | 175 +++++++++++++++++
 tb/tb_jt1942_dwnld.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/jt1942_dwnld.sv
// ROM download router for the 1942 core: maps ioctl bytes to SDRAM word/lane
// (object ROM interleaved), diverts PROM bytes to BRAM strobes, 2-deep write buffer.
module jt1942_dwnld #(
  parameter logic [21:0] PROM_START = 22'h3A000,
  parameter logic [21:0] OBJ_START  = 22'h2A000,
  parameter int          PROM_CNT   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic [21:0]         ioctl_addr,
  input  logic [7:0]          ioctl_data,
  input  logic                ioctl_wr,
  output logic [21:0]         prog_addr,
  output logic [7:0]          prog_data,
  output logic [1:0]          prog_mask,
  output logic                prog_we,
  input  logic                prog_ack,
  output logic [PROM_CNT-1:0] prom_we,
  output logic [7:0]          prom_addr,
  output logic [7:0]          prom_data,
  output logic                busy,
  output logic                ovf
);

  // Entry layout: {word[21:0], mask[1:0], data[7:0]}
  localparam logic [31:0] ENTRY_RST = {22'd0, 2'b11, 8'd0};

  logic                accept_s;
  logic [15:0]         obj_off_s;
  logic [21:0]         prom_off_s;
  logic                push_s;
  logic [31:0]         entry_s;
  logic                prom_hit_s;
  logic [PROM_CNT-1:0] prom_we_s;
  logic                pop_s;
  logic                drop_s;
  logic [31:0]         head_r, head_nx_s;
  logic [31:0]         tail_r, tail_nx_s;
  logic [1:0]          cnt_r, cnt_nx_s;
  logic                dl_d_r;
  logic                ovf_r;
  logic                busy_r;
  logic [PROM_CNT-1:0] prom_we_r;
  logic [7:0]          prom_addr_r;
  logic [7:0]          prom_data_r;

  assign accept_s   = downloading & ioctl_wr;
  // Only the low 16 bits of the object offset matter; modular subtraction keeps them exact.
  assign obj_off_s  = ioctl_addr[15:0] - OBJ_START[15:0];
  assign prom_off_s = ioctl_addr - PROM_START;

  // Address decode: SDRAM entry or PROM strobe for the accepted byte
  always_comb begin
    push_s     = 1'b0;
    entry_s    = ENTRY_RST;
    prom_hit_s = 1'b0;
    prom_we_s  = '0;
    if (!accept_s) begin
      push_s = 1'b0;
    end else if (ioctl_addr < OBJ_START) begin
      push_s  = 1'b1;
      entry_s = {{1'b0, ioctl_addr[21:1]}, (ioctl_addr[0] ? 2'b01 : 2'b10), ioctl_data};
    end else if (ioctl_addr < PROM_START) begin
      push_s  = 1'b1;
      entry_s = {(OBJ_START >> 1) + {7'd0, obj_off_s[14:0]},
                 (obj_off_s[15] ? 2'b01 : 2'b10), ioctl_data};
    end else if (prom_off_s[21:8] < 14'(PROM_CNT)) begin
      prom_hit_s = 1'b1;
      for (int i = 0; i < PROM_CNT; i++) begin
        prom_we_s[i] = (prom_off_s[21:8] == 14'(i));
      end
    end else begin
      push_s = 1'b0;
    end
  end

  assign pop_s = prog_ack & (cnt_r != 2'd0);

  // FIFO next state: head always presents the oldest entry
  always_comb begin
    head_nx_s = head_r;
    tail_nx_s = tail_r;
    cnt_nx_s  = cnt_r;
    drop_s    = 1'b0;
    case (cnt_r)
      2'd0: begin
        if (push_s) begin
          head_nx_s = entry_s;
          cnt_nx_s  = 2'd1;
        end else begin
          cnt_nx_s  = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          head_nx_s = entry_s;
        end else if (push_s) begin
          tail_nx_s = entry_s;
          cnt_nx_s  = 2'd2;
        end else if (pop_s) begin
          cnt_nx_s  = 2'd0;
        end else begin
          cnt_nx_s  = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_nx_s = tail_r;
          if (push_s) tail_nx_s = entry_s;
          else        cnt_nx_s  = 2'd1;
        end else if (push_s) begin
          drop_s = 1'b1;
        end else begin
          cnt_nx_s = 2'd2;
        end
      end
      default: cnt_nx_s = 2'd0;
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= ENTRY_RST;
      tail_r <= ENTRY_RST;
      cnt_r  <= 2'd0;
    end else begin
      head_r <= head_nx_s;
      tail_r <= tail_nx_s;
      cnt_r  <= cnt_nx_s;
    end
  end

  // Status: sticky overflow cleared on a new download window, busy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_d_r <= 1'b0;
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      dl_d_r <= downloading;
      busy_r <= downloading | (cnt_r != 2'd0);
      if (drop_s)                     ovf_r <= 1'b1;
      else if (downloading && !dl_d_r) ovf_r <= 1'b0;
      else                            ovf_r <= ovf_r;
    end
  end

  // PROM strobe lasts exactly one cycle; address/data held afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prom_we_r   <= '0;
      prom_addr_r <= 8'd0;
      prom_data_r <= 8'd0;
    end else begin
      prom_we_r <= prom_we_s;
      if (prom_hit_s) begin
        prom_addr_r <= prom_off_s[7:0];
        prom_data_r <= ioctl_data;
      end
    end
  end

  assign prog_addr = head_r[31:10];
  assign prog_mask = head_r[9:8];
  assign prog_data = head_r[7:0];
  assign prog_we   = (cnt_r != 2'd0);
  assign prom_we   = prom_we_r;
  assign prom_addr = prom_addr_r;
  assign prom_data = prom_data_r;
  assign busy      = busy_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_jt1942_dwnld.sv
// Directed self-checking bench for jt1942_dwnld with hand-computed expectations.
module tb_jt1942_dwnld;

  localparam logic [21:0] PROM_START = 22'h3A000;
  localparam logic [21:0] OBJ_START  = 22'h2A000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = 22'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_ack = 1'b0;
  logic [7:0]  prom_we;
  logic [7:0]  prom_addr;
  logic [7:0]  prom_data;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  jt1942_dwnld #(.PROM_START(PROM_START), .OBJ_START(OBJ_START), .PROM_CNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_ack(prog_ack),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic ack();
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [21:0] a,
                            input logic [1:0] m, input logic [7:0] d);
    check({tag, "_we"},   {31'd0, prog_we}, 32'd1);
    check({tag, "_addr"}, {10'd0, prog_addr}, {10'd0, a});
    check({tag, "_mask"}, {30'd0, prog_mask}, {30'd0, m});
    check({tag, "_data"}, {24'd0, prog_data}, {24'd0, d});
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      downloading = 1'($urandom);
      ioctl_wr    = 1'($urandom);
      prog_ack    = 1'($urandom);
      ioctl_addr  = 22'($urandom);
      ioctl_data  = 8'($urandom);
      tick();
    end
    check("rst_addr", {10'd0, prog_addr}, 32'd0);
    check("rst_data", {24'd0, prog_data}, 32'd0);
    check("rst_mask", {30'd0, prog_mask}, 32'd3);
    check("rst_we", {31'd0, prog_we}, 32'd0);
    check("rst_prom_we", {24'd0, prom_we}, 32'd0);
    check("rst_prom_addr", {24'd0, prom_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    downloading = 1'b0; ioctl_wr = 1'b0; prog_ack = 1'b0;
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_we", {31'd0, prog_we}, 32'd0);

    // ioctl_wr outside the download window is ignored
    wr_byte(22'h00004, 8'h99);
    check("nodl_we", {31'd0, prog_we}, 32'd0);

    downloading = 1'b1;
    tick(); tick();
    check("busy_dl", {31'd0, busy}, 32'd1);

    // Low region, ack after 3 cycles
    wr_byte(22'h00005, 8'hA5);
    check_head("low", 22'h00002, 2'b01, 8'hA5);
    tick();
    check("low_hold1", {31'd0, prog_we}, 32'd1);
    tick();
    check_head("low_hold2", 22'h00002, 2'b01, 8'hA5);
    ack();
    check("low_drop", {31'd0, prog_we}, 32'd0);

    // Object ROM interleave
    wr_byte(OBJ_START + 22'h08003, 8'h5A);
    check_head("obj_hi", 22'h15003, 2'b01, 8'h5A);
    ack();
    wr_byte(OBJ_START + 22'h00003, 8'h77);
    check_head("obj_lo", 22'h15003, 2'b10, 8'h77);
    ack();
    check("obj_drop", {31'd0, prog_we}, 32'd0);

    // PROM path
    wr_byte(PROM_START + 22'h002FF, 8'h3C);
    check("prom_we", {24'd0, prom_we}, 32'h04);
    check("prom_addr", {24'd0, prom_addr}, 32'hFF);
    check("prom_data", {24'd0, prom_data}, 32'h3C);
    check("prom_nosd", {31'd0, prog_we}, 32'd0);
    tick();
    check("prom_we_1cyc", {24'd0, prom_we}, 32'd0);
    check("prom_nosd2", {31'd0, prog_we}, 32'd0);

    // Beyond the PROM area: silently discarded
    wr_byte(PROM_START + 22'h00800, 8'hEE);
    check("beyond_we", {31'd0, prog_we}, 32'd0);
    check("beyond_prom", {24'd0, prom_we}, 32'd0);
    check("beyond_ovf", {31'd0, ovf}, 32'd0);

    // Ack while empty is ignored
    ack();
    wr_byte(22'h00006, 8'h42);
    check_head("emptyack", 22'h00003, 2'b10, 8'h42);
    ack();
    check("emptyack_drain", {31'd0, prog_we}, 32'd0);

    // Backpressure: three bytes back-to-back, no ack
    ioctl_wr = 1'b1;
    ioctl_addr = 22'h00010; ioctl_data = 8'h11; tick();
    ioctl_addr = 22'h00011; ioctl_data = 8'h22; tick();
    ioctl_addr = 22'h00012; ioctl_data = 8'h33; tick();
    ioctl_wr = 1'b0;
    check("bp_ovf", {31'd0, ovf}, 32'd1);
    check_head("bp_first", 22'h00008, 2'b10, 8'h11);
    ack();
    check_head("bp_second", 22'h00008, 2'b01, 8'h22);
    ack();
    check("bp_empty", {31'd0, prog_we}, 32'd0);
    check("bp_ovf_sticky", {31'd0, ovf}, 32'd1);
    downloading = 1'b0; tick();
    downloading = 1'b1; tick();
    check("bp_ovf_clr", {31'd0, ovf}, 32'd0);

    // Push and pop together while full
    wr_byte(22'h00020, 8'hD1);
    wr_byte(22'h00021, 8'hD2);
    ioctl_addr = 22'h00022; ioctl_data = 8'hD3; ioctl_wr = 1'b1; prog_ack = 1'b1;
    tick();
    ioctl_wr = 1'b0; prog_ack = 1'b0;
    check("sim_ovf", {31'd0, ovf}, 32'd0);
    check_head("sim_head", 22'h00010, 2'b01, 8'hD2);
    downloading = 1'b0;
    ack();
    check_head("sim_next", 22'h00011, 2'b10, 8'hD3);
    check("sim_busy", {31'd0, busy}, 32'd1);
    ack();
    check("sim_empty", {31'd0, prog_we}, 32'd0);
    tick();
    check("sim_idle", {31'd0, busy}, 32'd0);

    // Reset mid-download clears queued writes immediately
    downloading = 1'b1;
    tick();
    wr_byte(22'h00030, 8'h01);
    wr_byte(22'h00031, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_we", {31'd0, prog_we}, 32'd0);
    check("mrst_mask", {30'd0, prog_mask}, 32'd3);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    downloading = 1'b0;
    tick();
    check("mrst_idle", {31'd0, prog_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
